// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - control-unit to datapath bundle: IR fields and Zero in, select/enable lines out
interface mc_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       mRD;
    logic       mWR;
    logic [2:0] state;
    logic       illegal;

    modport master (
        input  opcode, funct, Zero,
        output PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, DBDataSrc,
               ALUSrcB, ExtSel, ALUOp, mRD, mWR, state, illegal
    );

    modport slave (
        output opcode, funct, Zero,
        input  PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, DBDataSrc,
               ALUSrcB, ExtSel, ALUOp, mRD, mWR, state, illegal
    );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS-subset control FSM; ILLEGAL_TRAP_EN halts on unknown opcode/funct
module mc_control_unit #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic              CLK,
    input  logic              Reset,
    mc_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_e     state_q, state_d;
    logic       halt_q, halt_d;
    logic       is_rtype, funct_known;
    logic [2:0] alu_rtype;
    logic       pc_wre, ir_wre, reg_wre, wr_reg_d_src, db_data_src;
    logic       alu_src_b, ext_sel, m_rd, m_wr;
    logic [1:0] pc_src, reg_dst;
    logic [2:0] alu_op;

    assign is_rtype = (bus.opcode == OP_RTYPE);

    always_comb begin
        alu_rtype   = ALU_ADD;
        funct_known = 1'b1;
        case (bus.funct)
            6'b100000: alu_rtype = ALU_ADD;
            6'b100010: alu_rtype = ALU_SUB;
            6'b100100: alu_rtype = ALU_AND;
            6'b100101: alu_rtype = ALU_OR;
            6'b101010: alu_rtype = ALU_SLT;
            default:   funct_known = 1'b0;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic op_known;
    assign op_known = bus.opcode inside {OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW,
                                         OP_BEQ, OP_J, OP_JAL, HALT_OP};
`endif

    always_comb begin
        state_d      = state_q;
        halt_d       = halt_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        pc_wre       = 1'b0;
        pc_src       = 2'b00;
        ir_wre       = 1'b0;
        reg_wre      = 1'b0;
        reg_dst      = 2'b00;
        wr_reg_d_src = 1'b0;
        db_data_src  = 1'b0;
        alu_src_b    = 1'b0;
        ext_sel      = 1'b0;
        alu_op       = ALU_ADD;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        // A halted FSM sits in IF with every enable low until reset.
        if (!halt_q) begin
            case (state_q)
                S_IF: begin
                    ir_wre  = 1'b1;
                    state_d = S_ID;
                end
                S_ID: begin
                    state_d = S_IF;
`ifdef ILLEGAL_TRAP_EN
                    if (!op_known || (is_rtype && !funct_known)) begin
                        halt_d    = 1'b1;
                        illegal_d = 1'b1;
                    end else
`endif
                    if (bus.opcode == OP_J) begin
                        pc_wre = 1'b1;
                        pc_src = 2'b10;
                    end else if (bus.opcode == OP_JAL) begin
                        pc_wre  = 1'b1;
                        pc_src  = 2'b10;
                        reg_wre = 1'b1;
                    end else if (bus.opcode == HALT_OP) begin
                        halt_d = 1'b1;
                    end else if (bus.opcode == OP_BEQ) begin
                        state_d = S_EXE_BR;
                    end else if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                        state_d = S_EXE_LS;
                    end else if (is_rtype || bus.opcode == OP_ADDI || bus.opcode == OP_ORI) begin
                        state_d = S_EXE_AL;
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    if (is_rtype) begin
                        alu_op = alu_rtype;
                    end else if (bus.opcode == OP_ADDI) begin
                        alu_src_b = 1'b1;
                        ext_sel   = 1'b1;
                    end else begin
                        alu_src_b = 1'b1;
                        alu_op    = ALU_OR;
                    end
                    if (state_q == S_EXE_AL) begin
                        state_d = S_WB_AL;
                    end else begin
                        // Unknown funct still retires the instruction, just without writeback.
                        reg_wre      = !is_rtype || funct_known;
                        reg_dst      = is_rtype ? 2'b10 : 2'b01;
                        wr_reg_d_src = 1'b1;
                        pc_wre       = 1'b1;
                        state_d      = S_IF;
                    end
                end
                S_EXE_BR: begin
                    alu_op  = ALU_SUB;
                    ext_sel = 1'b1;
                    pc_wre  = 1'b1;
                    pc_src  = bus.Zero ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end
                S_EXE_LS: begin
                    alu_src_b = 1'b1;
                    ext_sel   = 1'b1;
                    state_d   = S_MEM;
                end
                S_MEM: begin
                    if (bus.opcode == OP_SW) begin
                        m_wr    = 1'b1;
                        pc_wre  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        m_rd    = 1'b1;
                        state_d = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    reg_wre      = 1'b1;
                    reg_dst      = 2'b01;
                    wr_reg_d_src = 1'b1;
                    db_data_src  = 1'b1;
                    m_rd         = 1'b1;
                    pc_wre       = 1'b1;
                    state_d      = S_IF;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_IF;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge CLK) begin
        if (!Reset) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
    assign bus.illegal = Reset & illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    // Reset is sampled synchronously, but the outputs are quiet for as long as it is held.
    assign bus.InsMemRW  = 1'b1;
    assign bus.PCWre     = Reset & pc_wre;
    assign bus.PCSrc     = Reset ? pc_src : 2'b00;
    assign bus.IRWre     = Reset & ir_wre;
    assign bus.RegWre    = Reset & reg_wre;
    assign bus.RegDst    = Reset ? reg_dst : 2'b00;
    assign bus.WrRegDSrc = Reset & wr_reg_d_src;
    assign bus.DBDataSrc = Reset & db_data_src;
    assign bus.ALUSrcB   = Reset & alu_src_b;
    assign bus.ExtSel    = Reset & ext_sel;
    assign bus.ALUOp     = Reset ? alu_op : 3'b000;
    assign bus.mRD       = Reset & m_rd;
    assign bus.mWR       = Reset & m_wr;
    assign bus.state     = Reset ? state_q : S_IF;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed bench for mc_control_unit
module tb_mc_control_unit;
    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    mc_control_unit_if bus ();

    mc_control_unit #(.HALT_OP(6'b111111)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.Zero   = z;
    endtask

    // Starts in IF; runs until the FSM is back in IF, counting cycles and PCWre pulses.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int exp_cycles, input int exp_pcw);
        int cyc = 0;
        int pcw = 0;
        int bad = 0;
        set_ir(op, fn, z);
        do begin
            pcw += int'(bus.PCWre);
            if (bus.RegDst == 2'b11 || bus.PCSrc == 2'b11 || (bus.RegWre && bus.mWR)) bad++;
            cyc++;
            next_cycle();
        end while (bus.state != 3'd0 && cyc < 12);
        check_eq({tag, "_cycles"}, cyc, exp_cycles);
        check_eq({tag, "_pcwre"}, pcw, exp_pcw);
        check_eq({tag, "_invariant"}, bad, 0);
    endtask

    initial begin
        Reset = 1'b0;
        set_ir(6'b000000, 6'b100000, 1'b0);
        repeat (2) next_cycle();
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_insmem", bus.InsMemRW, 1);
        check_eq("rst_irwre", bus.IRWre, 0);
        check_eq("rst_pcwre", bus.PCWre, 0);

        // R-type add walk
        Reset = 1'b1;
        #1;
        check_eq("add_if_state", bus.state, 0);
        check_eq("add_if_irwre", bus.IRWre, 1);
        next_cycle(); check_eq("add_id_state", bus.state, 1);
        next_cycle(); check_eq("add_exe_state", bus.state, 6);
        check_eq("add_exe_aluop", bus.ALUOp, 0);
        check_eq("add_exe_regwre", bus.RegWre, 0);
        next_cycle(); check_eq("add_wb_state", bus.state, 7);
        check_eq("add_wb_regwre", bus.RegWre, 1);
        check_eq("add_wb_regdst", bus.RegDst, 2);
        check_eq("add_wb_aluop", bus.ALUOp, 0);
        check_eq("add_wb_pcwre", bus.PCWre, 1);
        check_eq("add_wb_wrsrc", bus.WrRegDSrc, 1);
        next_cycle(); check_eq("add_back_if", bus.state, 0);

        // addi
        set_ir(6'b001000, 6'b000000, 1'b0);
        next_cycle(); next_cycle();
        check_eq("addi_exe_alusrcb", bus.ALUSrcB, 1);
        check_eq("addi_exe_extsel", bus.ExtSel, 1);
        next_cycle();
        check_eq("addi_wb_regdst", bus.RegDst, 1);
        check_eq("addi_wb_extsel", bus.ExtSel, 1);
        next_cycle();

        // ori
        set_ir(6'b001101, 6'b000000, 1'b0);
        next_cycle(); next_cycle();
        check_eq("ori_exe_aluop", bus.ALUOp, 3);
        check_eq("ori_exe_extsel", bus.ExtSel, 0);
        next_cycle();
        check_eq("ori_wb_regdst", bus.RegDst, 1);
        check_eq("ori_wb_alusrcb", bus.ALUSrcB, 1);
        next_cycle();

        // slt and sub ALUOp decoding
        set_ir(6'b000000, 6'b101010, 1'b0);
        next_cycle(); next_cycle();
        check_eq("slt_aluop", bus.ALUOp, 4);
        next_cycle(); next_cycle();
        set_ir(6'b000000, 6'b100010, 1'b0);
        next_cycle(); next_cycle();
        check_eq("sub_aluop", bus.ALUOp, 1);
        next_cycle(); next_cycle();

        // lw walk
        set_ir(6'b100011, 6'b000000, 1'b0);
        next_cycle(); next_cycle();
        check_eq("lw_exe_state", bus.state, 2);
        check_eq("lw_exe_alusrcb", bus.ALUSrcB, 1);
        next_cycle();
        check_eq("lw_mem_state", bus.state, 3);
        check_eq("lw_mem_mrd", bus.mRD, 1);
        check_eq("lw_mem_pcwre", bus.PCWre, 0);
        next_cycle();
        check_eq("lw_wb_state", bus.state, 4);
        check_eq("lw_wb_regdst", bus.RegDst, 1);
        check_eq("lw_wb_dbsrc", bus.DBDataSrc, 1);
        check_eq("lw_wb_regwre", bus.RegWre, 1);
        next_cycle();

        // sw walk
        set_ir(6'b101011, 6'b000000, 1'b0);
        next_cycle(); next_cycle(); next_cycle();
        check_eq("sw_mem_mwr", bus.mWR, 1);
        check_eq("sw_mem_regwre", bus.RegWre, 0);
        check_eq("sw_mem_pcwre", bus.PCWre, 1);
        next_cycle();

        // beq taken / not taken
        set_ir(6'b000100, 6'b000000, 1'b1);
        next_cycle(); next_cycle();
        check_eq("beq1_state", bus.state, 5);
        check_eq("beq1_pcsrc", bus.PCSrc, 1);
        check_eq("beq1_aluop", bus.ALUOp, 1);
        next_cycle();
        set_ir(6'b000100, 6'b000000, 1'b0);
        next_cycle(); next_cycle();
        check_eq("beq0_pcsrc", bus.PCSrc, 0);
        check_eq("beq0_pcwre", bus.PCWre, 1);
        next_cycle();

        // jal
        set_ir(6'b000011, 6'b000000, 1'b0);
        next_cycle();
        check_eq("jal_regwre", bus.RegWre, 1);
        check_eq("jal_regdst", bus.RegDst, 0);
        check_eq("jal_wrsrc", bus.WrRegDSrc, 0);
        check_eq("jal_pcsrc", bus.PCSrc, 2);
        next_cycle();
        check_eq("jal_back_if", bus.state, 0);

        // cycle counts and PCWre-once-per-instruction
        run_instr("cnt_add", 6'b000000, 6'b100101, 1'b0, 4, 1);
        run_instr("cnt_lw", 6'b100011, 6'b000000, 1'b0, 5, 1);
        run_instr("cnt_sw", 6'b101011, 6'b000000, 1'b0, 4, 1);
        run_instr("cnt_beq", 6'b000100, 6'b000000, 1'b1, 3, 1);
        run_instr("cnt_j", 6'b000010, 6'b000000, 1'b0, 2, 1);

`ifndef ILLEGAL_TRAP_EN
        run_instr("nop_op", 6'b010101, 6'b000000, 1'b0, 2, 0);
        set_ir(6'b000000, 6'b000001, 1'b0);
        next_cycle(); next_cycle(); next_cycle();
        check_eq("badfn_regwre", bus.RegWre, 0);
        check_eq("badfn_pcwre", bus.PCWre, 1);
        next_cycle();
        check_eq("badfn_illegal", bus.illegal, 0);
`endif

        // reset mid-EXE_LS
        set_ir(6'b100011, 6'b000000, 1'b0);
        next_cycle(); next_cycle();
        check_eq("midrst_exe", bus.state, 2);
        Reset = 1'b0;
        #1;
        check_eq("midrst_quiet", bus.ALUSrcB, 0);
        next_cycle();
        Reset = 1'b1;
        #1;
        check_eq("midrst_if", bus.state, 0);
        check_eq("midrst_irwre", bus.IRWre, 1);

        // HALT_OP parks the FSM
        begin
            int pcw = 0;
            int irw = 0;
            set_ir(6'b111111, 6'b000000, 1'b0);
            next_cycle();
            for (int i = 0; i < 10; i++) begin
                next_cycle();
                pcw += int'(bus.PCWre);
                irw += int'(bus.IRWre);
            end
            check_eq("halt_pcwre", pcw, 0);
            check_eq("halt_irwre", irw, 0);
            check_eq("halt_state", bus.state, 0);
        end
        Reset = 1'b0;
        next_cycle();
        Reset = 1'b1;
        #1;
        check_eq("unhalt_irwre", bus.IRWre, 1);

`ifdef ILLEGAL_TRAP_EN
        set_ir(6'b010101, 6'b000000, 1'b0);
        next_cycle();
        check_eq("trap_id_pcwre", bus.PCWre, 0);
        next_cycle();
        check_eq("trap_illegal", bus.illegal, 1);
        check_eq("trap_irwre", bus.IRWre, 0);
        next_cycle();
        check_eq("trap_sticky", bus.illegal, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle MIPS-subset control FSM; the producer side of the datapath select lines.
- Drives the 2-bit RegDst code consumed by the 3-way write-register selector:
  - 00 selects $31.
  - 01 selects rt.
  - 10 selects rd.
- Also drives PC, IR, memory, ALU and write-back controls, from the IR opcode/funct fields and the ALU Zero flag.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag, valid in EXE_BR.
- PCWre  out  1  PC write enable.
- PCSrc  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target; 11 never driven.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read, constant 1.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write-register select: 00 $31, 01 rt, 10 rd; 11 never driven.
- WrRegDSrc  out  1  write data source: 0 PC+4 (jal), 1 DB.
- DBDataSrc  out  1  DB source: 0 ALU result, 1 memory data.
- ALUSrcB  out  1  ALU B operand: 0 register B, 1 extended immediate.
- ExtSel  out  1  extension mode: 0 zero-extend, 1 sign-extend.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- state  out  3  current state, for debug.
- illegal  out  1  illegal instruction flag; driven only when ILLEGAL_TRAP_EN is defined, else tied 0.

Behaviour:
- State encoding: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111. HALT reuses 000 plus a sticky internal halt bit.
- Supported opcodes:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010, jal 000011, HALT_OP.
- Reset:
  - Reset==0 at a rising edge puts the FSM in IF with the halt bit cleared.
  - Reset overrides every other event in that cycle, including mid-instruction.
  - While in reset, all outputs are 0 except InsMemRW=1.
- Registers and decode: the state register is the only sequential element besides the halt bit. Outputs are combinational from state, opcode, funct and Zero.
- Default output values: every output not listed for a state is 0, except InsMemRW=1.
- Transitions and per-state outputs:
  - IF: IRWre=1. Next state ID.
  - ID, opcode j: PCWre=1, PCSrc=10. Next state IF.
  - ID, opcode jal: PCWre=1, PCSrc=10, RegWre=1, RegDst=00, WrRegDSrc=0. Next state IF.
  - ID, HALT_OP: set the halt bit; all enables stay 0 until reset.
  - ID, beq: next state EXE_BR.
  - ID, lw or sw: next state EXE_LS.
  - ID, R-type, addi or ori: next state EXE_AL.
  - ID, unknown opcode: next state IF, no writes, PC unchanged.
  - EXE_AL, R-type: ALUOp from funct. Unknown funct behaves as add with no writeback.
  - EXE_AL, addi: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - EXE_AL, ori: ALUSrcB=1, ExtSel=0, ALUOp=011.
  - EXE_AL: next state WB_AL.
  - WB_AL: hold the ALU controls, RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. RegDst=10 for R-type, 01 for addi/ori. Next state IF.
  - EXE_BR: ALUOp=001, PCWre=1, PCSrc = Zero ? 01 : 00, ExtSel=1. Next state IF.
  - EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000. Next state MEM.
  - MEM, sw: mWR=1, PCWre=1, PCSrc=00. Next state IF.
  - MEM, lw: mRD=1. Next state WB_LD.
  - WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, mRD=1, PCWre=1, PCSrc=00. Next state IF.
- Cycle counts per instruction: R/addi/ori 4, lw 5, sw 4, beq 3, j/jal 2.
- Invariants:
  - RegDst and PCSrc never take 11.
  - RegWre and mWR are never both 1.
  - PCWre=1 in exactly one cycle per completed instruction.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in ID, or an unknown R-type funct in ID, sets the halt bit and raises illegal=1. illegal stays 1 until reset; no PC or register write occurs.
- Undefined: unknown opcode executes as a 2-cycle NOP; unknown funct completes without RegWre; illegal is tied 0.

Test Plan:
- Reset=0 for 2 cycles, then release with opcode=000000, funct=100000 -> states IF,ID,EXE_AL,WB_AL,IF. In WB_AL: RegWre=1, RegDst=10, ALUOp=000, PCWre=1.
- addi, then ori -> WB_AL shows RegDst=01. ExtSel=1 for addi, 0 for ori. ALUSrcB=1 for both.
- lw -> 5 cycles, WB_LD shows RegDst=01, DBDataSrc=1. sw -> MEM shows mWR=1, RegWre=0.
- beq with Zero=1 -> EXE_BR shows PCSrc=01. beq with Zero=0 -> PCSrc=00. Both take 3 cycles.
- jal -> ID shows RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=10; back in IF next cycle.
- Opcode 111111 -> halt, PCWre stays 0 for 10 cycles. Reset=0 asserted mid-EXE_LS -> IF next edge.
- Opcode 010101 -> NOP without ILLEGAL_TRAP_EN; with it, halt and illegal=1.
